// File: rtl/lif_neuron_nin.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_nin
// Brief    : N_IN-input leaky integrate-and-fire neuron, saturating signed
//            membrane, shift leak, refractory period in time steps.
//            Define LIF_SPIKE_COUNT_EN to add count_clr / spike_count.
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron_nin #(
  parameter int N_IN         = 4,
  parameter int W_WIDTH      = 8,
  parameter int P_WIDTH      = 16,
  parameter int THRESHOLD    = 100,
  parameter int LEAK_SHIFT   = 3,
  parameter int REFRAC_STEPS = 2,
  parameter int V_RESET      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      step_valid,
  input  logic [N_IN-1:0]           spikes_in,
  input  logic [N_IN*W_WIDTH-1:0]   weights,
`ifdef LIF_SPIKE_COUNT_EN
  input  logic                      count_clr,
  output logic [15:0]               spike_count,
`endif
  output logic                      spike_out,
  output logic                      out_valid,
  output logic signed [P_WIDTH-1:0] potential,
  output logic                      refractory
);

  localparam int c_SUM_W = P_WIDTH + $clog2(N_IN) + 1;
  localparam int c_CNT_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  localparam logic signed [c_SUM_W-1:0] c_P_MAX = (c_SUM_W)'(2**(P_WIDTH-1) - 1);
  localparam logic signed [c_SUM_W-1:0] c_P_MIN = (c_SUM_W)'(-(2**(P_WIDTH-1)));
  localparam logic signed [c_SUM_W-1:0] c_THR   = (c_SUM_W)'(THRESHOLD);
  localparam logic signed [P_WIDTH-1:0] c_VRST  = (P_WIDTH)'(V_RESET);
  localparam logic [c_CNT_W-1:0]        c_REFRAC = (c_CNT_W)'(REFRAC_STEPS);
  localparam logic [c_CNT_W-1:0]        c_CNT_ONE = (c_CNT_W)'(1);

  typedef enum logic [0:0] {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;

  logic signed [c_SUM_W-1:0] w_syn;
  logic signed [c_SUM_W-1:0] w_p_wide;
  logic signed [c_SUM_W-1:0] w_leaked;
  logic signed [c_SUM_W-1:0] w_sum;
  logic signed [c_SUM_W-1:0] w_sat;
  logic signed [P_WIDTH-1:0] w_nxt;
  logic                      w_fire;
  logic                      w_int_step;
  logic                      w_spike_now;

  // Weights are sign-extended to the wide width before accumulation.
  always_comb begin
    w_syn = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spikes_in[i]) begin
        w_syn = w_syn + (c_SUM_W)'($signed(weights[i*W_WIDTH +: W_WIDTH]));
      end
    end
  end

  assign w_p_wide = (c_SUM_W)'(potential);
  assign w_leaked = w_p_wide - (w_p_wide >>> LEAK_SHIFT);
  assign w_sum    = w_leaked + w_syn;

  always_comb begin
    w_sat = w_sum;
    if (w_sum > c_P_MAX) begin
      w_sat = c_P_MAX;
    end else if (w_sum < c_P_MIN) begin
      w_sat = c_P_MIN;
    end
  end

  assign w_nxt       = w_sat[P_WIDTH-1:0];
  assign w_fire      = (w_sat >= c_THR);
  assign w_int_step  = step_valid && (r_state == ST_INTEGRATE);
  assign w_spike_now = w_int_step && w_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INTEGRATE;
      r_cnt      <= '0;
      potential  <= c_VRST;
      spike_out  <= 1'b0;
      out_valid  <= 1'b0;
      refractory <= 1'b0;
    end else begin
      spike_out <= 1'b0;
      out_valid <= step_valid;
      if (step_valid) begin
        case (r_state)
          ST_INTEGRATE: begin
            if (w_spike_now) begin
              spike_out <= 1'b1;
              potential <= c_VRST;
              if (REFRAC_STEPS > 0) begin
                r_cnt      <= c_REFRAC;
                refractory <= 1'b1;
                r_state    <= ST_REFRACTORY;
              end
            end else begin
              potential <= w_nxt;
            end
          end
          ST_REFRACTORY: begin
            // Inputs ignored; the step that reaches zero still ignores them.
            potential <= c_VRST;
            r_cnt     <= r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
              refractory <= 1'b0;
              r_state    <= ST_INTEGRATE;
            end
          end
          default: begin
            r_state <= ST_INTEGRATE;
          end
        endcase
      end
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  // Counter moves on the same edge that raises spike_out; clear dominates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_count <= '0;
    end else if (count_clr) begin
      spike_count <= '0;
    end else if (w_spike_now && (spike_count != 16'hFFFF)) begin
      spike_count <= spike_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_nin.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_neuron_nin
// Brief    : Self-checking bench for lif_neuron_nin (default and P_WIDTH=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_nin;

  localparam int N_IN = 4, W_WIDTH = 8, P_WIDTH = 16, THRESHOLD = 100;
  localparam int LEAK_SHIFT = 3, REFRAC_STEPS = 2, V_RESET = 0;
  localparam int P_MAX = 32767, P_MIN = -32768;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic step_valid = 1'b0;
  logic [3:0] spikes_in = '0;
  logic [31:0] weights = '0;
  logic spike_out, out_valid, refractory;
  logic signed [15:0] potential;

  logic sat_step = 1'b0;
  logic [3:0] sat_spikes = '0;
  logic [31:0] sat_weights = '0;
  logic sat_spike, sat_ov, sat_refr;
  logic signed [9:0] sat_pot;

`ifdef LIF_SPIKE_COUNT_EN
  logic count_clr = 1'b0;
  logic sat_clr = 1'b0;
  logic [15:0] spike_count, sat_count;
`endif

  int total = 0;
  int bad = 0;

  // Reference model state
  int m_p = V_RESET;
  int m_cnt = 0;
  bit m_spike = 1'b0;
  bit m_ov = 1'b0;

  always #5 clk = ~clk;

  lif_neuron_nin dut (
    .clk(clk), .rst_n(rst_n), .step_valid(step_valid),
    .spikes_in(spikes_in), .weights(weights),
`ifdef LIF_SPIKE_COUNT_EN
    .count_clr(count_clr), .spike_count(spike_count),
`endif
    .spike_out(spike_out), .out_valid(out_valid),
    .potential(potential), .refractory(refractory)
  );

  lif_neuron_nin #(.P_WIDTH(10)) dut_sat (
    .clk(clk), .rst_n(rst_n), .step_valid(sat_step),
    .spikes_in(sat_spikes), .weights(sat_weights),
`ifdef LIF_SPIKE_COUNT_EN
    .count_clr(sat_clr), .spike_count(sat_count),
`endif
    .spike_out(sat_spike), .out_valid(sat_ov),
    .potential(sat_pot), .refractory(sat_refr)
  );

  function automatic int floor_div_pow2(input int v, input int sh);
    int d;
    d = 1 << sh;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function void model_reset();
    m_p = V_RESET; m_cnt = 0; m_spike = 1'b0; m_ov = 1'b0;
  endfunction

  function void model_step(input bit v, input logic [3:0] sp, input logic [31:0] w);
    int syn, nxt, wi;
    m_spike = 1'b0;
    m_ov = v;
    if (!v) return;
    if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      m_p = V_RESET;
      return;
    end
    syn = 0;
    for (int i = 0; i < N_IN; i++) begin
      wi = int'($signed(w[i*W_WIDTH +: W_WIDTH]));
      if (sp[i]) syn = syn + wi;
    end
    nxt = m_p - floor_div_pow2(m_p, LEAK_SHIFT) + syn;
    if (nxt > P_MAX) nxt = P_MAX;
    if (nxt < P_MIN) nxt = P_MIN;
    if (nxt >= THRESHOLD) begin
      m_spike = 1'b1;
      m_p = V_RESET;
      m_cnt = REFRAC_STEPS;
    end else begin
      m_p = nxt;
    end
  endfunction

  task automatic drive(input bit v, input logic [3:0] sp, input logic [31:0] w);
    @(negedge clk);
    step_valid = v; spikes_in = sp; weights = w;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; step_valid = 1'b0; sat_step = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++; if (potential !== 16'sd0) begin bad++; $display("FAIL rst_async_pot got=%0d want=0", potential); end
    total++; if (refractory !== 1'b0) begin bad++; $display("FAIL rst_async_refr got=%b want=0", refractory); end
    repeat (2) @(negedge clk);
    total++; if (spike_out !== 1'b0) begin bad++; $display("FAIL rst_spike got=%b want=0", spike_out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_ov got=%b want=0", out_valid); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_integrate_fire();
    apply_reset();
    drive(1'b1, 4'b0011, {4{8'd30}});
    total++; if (potential !== 16'sd60) begin bad++; $display("FAIL if_s1_pot got=%0d want=60", potential); end
    total++; if (spike_out !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL if_s1_flags got=%b%b want=01", spike_out, out_valid); end
    drive(1'b1, 4'b0011, {4{8'd30}});
    total++; if (spike_out !== 1'b1) begin bad++; $display("FAIL if_s2_spike got=%b want=1", spike_out); end
    total++; if (potential !== 16'sd0 || refractory !== 1'b1) begin bad++; $display("FAIL if_s2_state got=%0d/%b want=0/1", potential, refractory); end
  endtask

  task automatic test_refractory();
    bit exp_refr [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 4'b1111, {4{8'd30}});
      total++; if (spike_out !== 1'b0 || potential !== 16'sd0) begin bad++; $display("FAIL refr_hold%0d got=%b/%0d want=0/0", k, spike_out, potential); end
      total++; if (refractory !== exp_refr[k]) begin bad++; $display("FAIL refr_flag%0d got=%b want=%b", k, refractory, exp_refr[k]); end
    end
    drive(1'b1, 4'b1111, {4{8'd30}});
    total++; if (spike_out !== 1'b1 || potential !== 16'sd0) begin bad++; $display("FAIL refr_resume got=%b/%0d want=1/0", spike_out, potential); end
  endtask

  task automatic test_leak_hold_reset();
    int exp_seq [3] = '{70, 62, 55};
    logic signed [15:0] e;
    apply_reset();
    drive(1'b1, 4'b0001, {24'd0, 8'd80});
    total++; if (potential !== 16'sd80) begin bad++; $display("FAIL leak_s0 got=%0d want=80", potential); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'b0000, {4{8'd77}});
      e = 16'(exp_seq[k]);
      total++; if (potential !== e) begin bad++; $display("FAIL leak_s%0d got=%0d want=%0d", k + 1, potential, e); end
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'($urandom), {4{8'd127}});
      total++; if (potential !== 16'sd55 || out_valid !== 1'b0 || spike_out !== 1'b0) begin
        bad++; $display("FAIL hold%0d got=%0d/%b/%b want=55/0/0", k, potential, out_valid, spike_out);
      end
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (potential !== 16'sd0) begin bad++; $display("FAIL async_mid got=%0d want=0", potential); end
    @(negedge clk);
    step_valid = 1'b1; spikes_in = 4'b1111; weights = {4{8'd127}};
    @(posedge clk); #1;
    step_valid = 1'b0;
    total++; if (spike_out !== 1'b0) begin bad++; $display("FAIL async_nospike got=%b want=0", spike_out); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 4'b1111, {4{8'd127}});
      total++; if (spike_out !== 1'b0 || potential !== 16'sd0) begin bad++; $display("FAIL post_rst%0d got=%b/%0d want=0/0", k, spike_out, potential); end
    end
    drive(1'b1, 4'b0001, {24'd0, 8'h80});
    total++; if (potential !== -16'sd128) begin bad++; $display("FAIL neg_s0 got=%0d want=-128", potential); end
    drive(1'b1, 4'b0000, 32'd0);
    total++; if (potential !== -16'sd112) begin bad++; $display("FAIL neg_s1 got=%0d want=-112", potential); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sat_step = 1'b1; sat_spikes = 4'b1111; sat_weights = {4{8'h80}};
      @(posedge clk); #1;
      total++; if (sat_pot !== -10'sd512) begin bad++; $display("FAIL sat_s%0d got=%0d want=-512", k, sat_pot); end
      total++; if (sat_spike !== 1'b0 || sat_ov !== 1'b1 || sat_refr !== 1'b0) begin
        bad++; $display("FAIL sat_flags%0d got=%b%b%b want=010", k, sat_spike, sat_ov, sat_refr);
      end
    end
    sat_step = 1'b0;
  endtask

  task automatic test_random_back_to_back();
    bit v;
    logic [3:0] sp;
    logic [31:0] w;
    logic signed [15:0] e;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      v = (n >= 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      sp = 4'($urandom);
      for (int i = 0; i < N_IN; i++) begin
        if (n % 3 == 0) w[i*8 +: 8] = 8'($urandom);
        else            w[i*8 +: 8] = 8'(int'($urandom_range(0, 50)) - 25);
      end
      drive(v, sp, w);
      model_step(v, sp, w);
      e = 16'(m_p);
      total++; if (potential !== e) begin bad++; $display("FAIL rnd%0d_pot got=%0d want=%0d", n, potential, e); end
      total++; if (spike_out !== m_spike) begin bad++; $display("FAIL rnd%0d_spike got=%b want=%b", n, spike_out, m_spike); end
      total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rnd%0d_ov got=%b want=%b", n, out_valid, m_ov); end
      total++; if (refractory !== (m_cnt != 0)) begin bad++; $display("FAIL rnd%0d_refr got=%b want=%b", n, refractory, (m_cnt != 0)); end
    end
  endtask

`ifdef LIF_SPIKE_COUNT_EN
  task automatic test_spike_count();
    apply_reset();
    for (int k = 0; k < 7; k++) drive(1'b1, 4'b1111, {4{8'd127}});
    total++; if (spike_count !== 16'd3) begin bad++; $display("FAIL cnt_three got=%0d want=3", spike_count); end
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL cnt_idle_inst got=%0d want=0", sat_count); end
    for (int k = 0; k < 2; k++) drive(1'b1, 4'b1111, {4{8'd127}});
    count_clr = 1'b1;
    drive(1'b1, 4'b1111, {4{8'd127}});
    count_clr = 1'b0;
    total++; if (spike_out !== 1'b1) begin bad++; $display("FAIL cnt_4th_spike got=%b want=1", spike_out); end
    total++; if (spike_count !== 16'd0) begin bad++; $display("FAIL cnt_clr_wins got=%0d want=0", spike_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_integrate_fire();
    test_refractory();
    test_leak_hold_reset();
    test_saturation();
    test_random_back_to_back();
`ifdef LIF_SPIKE_COUNT_EN
    test_spike_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
